// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
// Holds the arbiter state enum, the RAM-port owner encoding and the default bus widths.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH  = 12;
  localparam int unsigned DMEM_DATA_WIDTH  = 32;
  localparam int unsigned STARVE_CNT_WIDTH = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SEC  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU dmem port, the secondary requester and the RAM.
// slave  : arbiter view (CPU/secondary requests in, RAM controls out, read data in).
// master : environment view (CPU, secondary requester and RAM model).
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH
) ();

  logic                  cpu_access;
  logic                  cpu_wren;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic [DATA_WIDTH-1:0] cpu_q;
  logic                  cpu_stall;

  logic                  sec_req;
  logic                  sec_we;
  logic [ADDR_WIDTH-1:0] sec_addr;
  logic [DATA_WIDTH-1:0] sec_wdata;
  logic                  sec_gnt;
  logic [DATA_WIDTH-1:0] sec_rdata;
  logic                  sec_rvalid;

  logic                  ram_wEn;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dataIn;
  logic [DATA_WIDTH-1:0] ram_dataOut;

  modport slave (
    input  cpu_access, cpu_wren, cpu_addr, cpu_data,
    output cpu_q, cpu_stall,
    input  sec_req, sec_we, sec_addr, sec_wdata,
    output sec_gnt, sec_rdata, sec_rvalid,
    output ram_wEn, ram_addr, ram_dataIn,
    input  ram_dataOut
  );

  modport master (
    output cpu_access, cpu_wren, cpu_addr, cpu_data,
    input  cpu_q, cpu_stall,
    output sec_req, sec_we, sec_addr, sec_wdata,
    input  sec_gnt, sec_rdata, sec_rvalid,
    input  ram_wEn, ram_addr, ram_dataIn,
    output ram_dataOut
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive cycles the secondary requester was denied.
// Ports: clock, reset (sync, active-high), inc, clr, limit -> hit.
// hit flags the increment that reaches limit, i.e. the edge that must force a grant.
module arb_starve_counter
  import dmem_arb_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inc,
  input  logic                        clr,
  input  logic [STARVE_CNT_WIDTH-1:0] limit,
  output logic                        hit
);

  logic [STARVE_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + STARVE_CNT_WIDTH'(1);
    end
  end

  assign hit = inc && (cnt_q == (limit - STARVE_CNT_WIDTH'(1)));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store port and one
// secondary requester. CPU has priority; after STARVE_LIMIT denied cycles the
// CPU is stalled for one cycle (FORCE) and the secondary requester is served.
// Ports: clock, reset (sync, active-high), bus (dmem_arbiter_if.slave).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  arb_state_e            state_q, state_d;
  logic                  cpu_stall_q, cpu_stall_d;
  logic                  sec_rvalid_q, sec_rvalid_d;

  owner_e                owner_c;
  logic                  force_c;
  logic                  sec_gnt_c;
  logic                  starve_inc_c;
  logic                  starve_clr_c;
  logic                  starve_hit_c;
  logic                  ram_wen_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= NORMAL;
      cpu_stall_q  <= 1'b0;
      sec_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_stall_q  <= cpu_stall_d;
      sec_rvalid_q <= sec_rvalid_d;
    end
  end

  // Owner selection and RAM port mux; reset forces the NORMAL rules
  always_comb begin
    owner_c     = OWN_NONE;
    ram_wen_c   = 1'b0;
    ram_addr_c  = bus.cpu_addr;
    ram_wdata_c = bus.cpu_data;
    force_c     = (state_q == FORCE) && !reset;

    if (force_c) begin
      if (bus.sec_req) owner_c = OWN_SEC;
    end else if (bus.cpu_access) begin
      owner_c = OWN_CPU;
    end else if (bus.sec_req) begin
      owner_c = OWN_SEC;
    end

    case (owner_c)
      OWN_CPU: ram_wen_c = bus.cpu_wren;
      OWN_SEC: begin
        ram_wen_c   = bus.sec_we;
        ram_addr_c  = bus.sec_addr;
        ram_wdata_c = bus.sec_wdata;
      end
      default: ;
    endcase

    sec_gnt_c    = (owner_c == OWN_SEC);
    starve_inc_c = !force_c && bus.sec_req && !sec_gnt_c;
    starve_clr_c = sec_gnt_c || !bus.sec_req || force_c;
  end

  arb_starve_counter u_starve (
    .clock (clock),
    .reset (reset),
    .inc   (starve_inc_c),
    .clr   (starve_clr_c),
    .limit (STARVE_CNT_WIDTH'(STARVE_LIMIT)),
    .hit   (starve_hit_c)
  );

  // Next state; FORCE always lasts exactly one cycle
  always_comb begin
    state_d      = NORMAL;
    cpu_stall_d  = 1'b0;
    sec_rvalid_d = sec_gnt_c && !bus.sec_we;
    case (state_q)
      NORMAL:  state_d = starve_hit_c ? FORCE : NORMAL;
      FORCE:   state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
    cpu_stall_d = (state_d == FORCE);
  end

  assign bus.ram_wEn    = ram_wen_c;
  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_dataIn = ram_wdata_c;
  assign bus.sec_gnt    = sec_gnt_c;
  assign bus.cpu_stall  = cpu_stall_q;
  assign bus.sec_rvalid = sec_rvalid_q;
  assign bus.cpu_q      = bus.ram_dataOut;
  assign bus.sec_rdata  = bus.ram_dataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read RAM model and a
// scoreboard of expected secondary read data.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] sb[$];
  logic [31:0] mem [0:4095];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write commit and 1-cycle synchronous read
  always @(posedge clk) begin
    if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer for secondary read returns
  always @(negedge clk) begin
    if (bus.sec_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sec_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("sb_sec_rdata", bus.sec_rdata, sb.pop_front());
      end
    end
  end

  task automatic idle();
    bus.cpu_access = 1'b0;
    bus.cpu_wren   = 1'b0;
    bus.cpu_addr   = 12'h000;
    bus.cpu_data   = 32'h0;
    bus.sec_req    = 1'b0;
    bus.sec_we     = 1'b0;
    bus.sec_addr   = 12'h000;
    bus.sec_wdata  = 32'h0;
  endtask

  task automatic cpu_drive(input logic acc, input logic wr, input logic [11:0] a, input logic [31:0] d);
    bus.cpu_access = acc;
    bus.cpu_wren   = wr;
    bus.cpu_addr   = a;
    bus.cpu_data   = d;
  endtask

  task automatic sec_drive(input logic rq, input logic we, input logic [11:0] a, input logic [31:0] d);
    bus.sec_req   = rq;
    bus.sec_we    = we;
    bus.sec_addr  = a;
    bus.sec_wdata = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    bus.ram_dataOut = 32'h0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_sec_gnt", bus.sec_gnt, 0);
    chk("rst_sec_rvalid", bus.sec_rvalid, 0);
    chk("rst_ram_wEn", bus.ram_wEn, 0);

    // Idle-bus secondary write then read
    @(negedge clk);
    rst = 1'b0;
    sec_drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    #1;
    chk("idle_wr_gnt", bus.sec_gnt, 1);
    chk("idle_wr_wEn", bus.ram_wEn, 1);
    chk("idle_wr_addr", bus.ram_addr, 32'h010);
    chk("idle_wr_data", bus.ram_dataIn, 32'hDEADBEEF);
    @(negedge clk);
    sec_drive(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    chk("idle_rd_gnt", bus.sec_gnt, 1);
    chk("idle_rd_wEn", bus.ram_wEn, 0);
    sb.push_back(32'hDEADBEEF);
    @(negedge clk);
    idle();
    #1;
    chk("idle_rd_rvalid", bus.sec_rvalid, 1);
    chk("idle_rd_rdata", bus.sec_rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("idle_rvalid_clear", bus.sec_rvalid, 0);

    // Forced grant after four denied cycles
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      cpu_drive(1'b1, 1'b0, 12'h0AA, 32'h0);
      sec_drive(c <= 4, 1'b0, 12'h010, 32'h0);
      #1;
      chk($sformatf("force_stall_c%0d", c), bus.cpu_stall, (c == 4) ? 1 : 0);
      chk($sformatf("force_gnt_c%0d", c), bus.sec_gnt, (c == 4) ? 1 : 0);
      chk($sformatf("force_addr_c%0d", c), bus.ram_addr, (c == 4) ? 32'h010 : 32'h0AA);
      if (c == 4) sb.push_back(32'hDEADBEEF);
      if (c == 5) chk("force_rvalid", bus.sec_rvalid, 1);
    end

    // CPU priority and load pass-through
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 12'h020, 32'h12345678);
    sec_drive(1'b1, 1'b0, 12'h020, 32'h0);
    #1;
    chk("prio_wEn", bus.ram_wEn, 1);
    chk("prio_addr", bus.ram_addr, 32'h020);
    chk("prio_data", bus.ram_dataIn, 32'h12345678);
    chk("prio_gnt", bus.sec_gnt, 0);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 12'h020, 32'h0);
    #1;
    chk("prio_ld_wEn", bus.ram_wEn, 0);
    chk("prio_ld_gnt", bus.sec_gnt, 0);
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("prio_cpu_q", bus.cpu_q, 32'h12345678);
    chk("prio_sec_gnt_after", bus.sec_gnt, 1);
    sb.push_back(32'h12345678);
    @(negedge clk);
    idle();
    #1;
    chk("prio_rvalid", bus.sec_rvalid, 1);

    // sec_req dropped just before the forced grant restarts the count
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      cpu_drive(1'b1, 1'b0, 12'h055, 32'h0);
      sec_drive((c != 3) && (c <= 8), 1'b1, 12'h040, 32'hA5A5A5A5);
      #1;
      chk($sformatf("drop_stall_c%0d", c), bus.cpu_stall, (c == 8) ? 1 : 0);
      chk($sformatf("drop_gnt_c%0d", c), bus.sec_gnt, (c == 8) ? 1 : 0);
      if (c == 8) chk("drop_force_wEn", bus.ram_wEn, 1);
    end

    // Reset asserted in the FORCE cycle
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      cpu_drive(1'b1, 1'b0, 12'h066, 32'h0);
      sec_drive(1'b1, 1'b0, 12'h010, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstf_stall_held", bus.cpu_stall, 1);
    chk("rstf_gnt_normal", bus.sec_gnt, 0);
    chk("rstf_addr_cpu", bus.ram_addr, 32'h066);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rstf_stall_after", bus.cpu_stall, 0);
    chk("rstf_rvalid_after", bus.sec_rvalid, 0);

    // Reset during the grant cycle of a read drops the read
    @(negedge clk);
    rst = 1'b1;
    sec_drive(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    chk("rstr_gnt", bus.sec_gnt, 1);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rstr_rvalid", bus.sec_rvalid, 0);
    chk("rstr_stall", bus.cpu_stall, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
